count_display_driver: RTL and testbench
=======================================

// Module: count_display_driver
// PURPOSE
//   Downstream stage of the 1 s measurement counter. Takes the counter's 23-bit count_value,
//   converts it to BCD with a sequential double-dabble engine, and drives the board's
//   multiplexed-free 7-segment displays (one active-low 7-bit bus per digit).
//   Conversion starts automatically whenever the input value changes; no upstream valid needed.
// PARAMETERS
//   WIDTH       23   binary input width
//   NUM_DIGITS  6    displayed decimal digits (one 7-seg per digit)
// PORTS
//   clk         in   1               system clock (50 MHz)
//   rst         in   1               asynchronous, active-high reset
//   bin_in      in   WIDTH           binary value from the counter stage
//   bcd_out     out  4*NUM_DIGITS    registered BCD, digit 0 = LSD at [3:0]
//   hex_out     out  7*NUM_DIGITS    active-low segments {g..a}, digit 0 at [6:0]
//   overflow    out  1               value exceeds 10^NUM_DIGITS-1
//   done        out  1               one-cycle pulse when outputs update
// BEHAVIOUR
//   Reset (async, rst=1): bcd_out=0, hex_out = '0' pattern (7'b1000000) on every digit,
//     overflow=0, done=0, state=IDLE, last_val=0, force=1.
//   Internal digit count BCD_DIGITS = ceil(WIDTH*log10(2)) (7 for WIDTH=23).
//   FSM IDLE -> SHIFT -> UPDATE -> IDLE:
//   IDLE:   if force or bin_in != last_val: capture bin_in into shift reg and last_val,
//           clear BCD accumulator, bit_cnt=0, force=0 -> SHIFT. Else stay.
//   SHIFT:  each cycle, every BCD nibble >=5 gets +3, then {bcd,bin} shifted left 1;
//           bit_cnt++; after WIDTH shifts -> UPDATE.
//   UPDATE: register bcd_out/hex_out/overflow from accumulator, done=1 for this cycle -> IDLE.
//   Latency: bin_in change sampled at edge N -> outputs and done valid after edge N+WIDTH+1.
//   bin_in changes during SHIFT/UPDATE are ignored; IDLE re-compares, so the final stable
//     value is always converted (max 2*(WIDTH+2) cycles to settle).
//   Overflow: any BCD digit at index >= NUM_DIGITS nonzero -> overflow=1, bcd_out digits all
//     4'd9, hex_out shows '9' on every digit. Otherwise overflow=0, true digits shown.
//   Digit values 0-9 only; decoder maps any other nibble to all-off (7'h7F).
//   Reset mid-conversion aborts immediately; post-reset the force flag reconverts bin_in.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero digit are
//     blanked (7'h7F); digit 0 always lit (value 0 shows a single '0'); bcd_out unaffected;
//     reset shows '0' on digit 0 and blanks elsewhere. Not defined: all digits always lit.
// STRUCTURE
//   Shared include display_pkg.vh: SEG_0..SEG_9, SEG_BLANK constants; bcd_digits(width)
//     constant function; FSM state encodings ST_IDLE/ST_SHIFT/ST_UPDATE.
//   Sub-module seg7_decoder: combinational 4-bit BCD -> 7-bit active-low, instantiated
//     NUM_DIGITS times via generate; blanking muxed in count_display_driver.
// TESTING
//   Reset release, bin_in=0 -> done after WIDTH+2 cycles, hex_out all 7'b1000000, overflow=0.
//   bin_in=123456 -> after 25 cycles bcd_out=24'h123456, hex digit0=SEG_6, digit5=SEG_1.
//   bin_in=8388607 -> overflow=1, bcd_out=24'h999999, every digit SEG_9.
//   bin_in 42 -> 77 in mid-SHIFT -> first done shows 42, second done (<=50 cycles) shows 77.
//   With LEADING_ZERO_BLANK_EN, bin_in=305 -> digits 5..3 = 7'h7F, digits 2..0 = 3,0,5.
//   rst asserted during SHIFT -> outputs at reset values same cycle; reconverts after release.

Source files
------------

// File: rtl/count_display_driver_pkg.sv
// Shared constants for the count display path: segment patterns, FSM encodings
// and the binary-to-BCD digit-count helper.
package count_display_driver_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    // ceil(width * log10(2)) in integer arithmetic (log10(2) ~= 0.30103)
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes go dark.
module seg7_decoder
    import count_display_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // NOTE: the default arm assigns seg on every path, so no latch is inferred.
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display_driver.sv
// Sequential double-dabble binary->BCD converter driving one 7-seg bus per digit.
// Optional LEADING_ZERO_BLANK_EN: blank digits above the most significant nonzero one.
module count_display_driver
    import count_display_driver_pkg::*;
#(
    parameter int WIDTH      = 23,
    parameter int NUM_DIGITS = 6
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        bin_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    overflow,
    output logic                    done
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    // Accumulator never narrower than the display so the digit slice always exists
    localparam int ACC_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int CNT_W      = $clog2(WIDTH + 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7*NUM_DIGITS-1:0] HEX_RESET = {{(NUM_DIGITS-1){SEG_BLANK}}, SEG_0};
`else
    localparam logic [7*NUM_DIGITS-1:0] HEX_RESET = {NUM_DIGITS{SEG_0}};
`endif

    logic [1:0]              state;
    logic [WIDTH-1:0]        shift_reg;
    logic [WIDTH-1:0]        last_val;
    logic [4*ACC_DIGITS-1:0] bcd_acc;
    logic [4*ACC_DIGITS-1:0] bcd_adj;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    force_flag;

    logic                    acc_ovf;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic [7*NUM_DIGITS-1:0] dec_seg;
    logic [7*NUM_DIGITS-1:0] hex_next;

    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < ACC_DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
    end

    // Any nonzero digit beyond the display saturates the readout to all nines
    always_comb begin
        acc_ovf = 1'b0;
        for (int i = NUM_DIGITS; i < ACC_DIGITS; i++)
            acc_ovf = acc_ovf | (bcd_acc[4*i +: 4] != 4'd0);
        disp_bcd = acc_ovf ? {NUM_DIGITS{4'd9}} : bcd_acc[4*NUM_DIGITS-1:0];
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
        seg7_decoder u_dec (
            .bcd (disp_bcd[4*d +: 4]),
            .seg (dec_seg[7*d +: 7])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nonzero;

    always_comb begin
        hex_next     = dec_seg;
        seen_nonzero = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen_nonzero = seen_nonzero | (disp_bcd[4*i +: 4] != 4'd0);
            if (!seen_nonzero)
                hex_next[7*i +: 7] = SEG_BLANK;
        end
    end
`else
    always_comb begin
        hex_next = dec_seg;
    end
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            last_val   <= '0;
            bcd_acc    <= '0;
            bit_cnt    <= '0;
            force_flag <= 1'b1;
            bcd_out    <= '0;
            hex_out    <= HEX_RESET;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (force_flag || (bin_in != last_val)) begin
                        shift_reg  <= bin_in;
                        last_val   <= bin_in;
                        bcd_acc    <= '0;
                        bit_cnt    <= '0;
                        force_flag <= 1'b0;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd_acc, shift_reg} <= {bcd_adj, shift_reg} << 1;
                    bit_cnt              <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(WIDTH - 1))
                        state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    bcd_out  <= disp_bcd;
                    hex_out  <= hex_next;
                    overflow <= acc_ovf;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: directed vector table, multi-cycle
// corner sequences and randomized values against a decimal-arithmetic model.
module tb_count_display_driver;

    localparam int WIDTH      = 23;
    localparam int NUM_DIGITS = 6;
    localparam int LATENCY    = WIDTH + 2;

    logic                    clk;
    logic                    rst;
    logic [WIDTH-1:0]        bin_in;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [7*NUM_DIGITS-1:0] hex_out;
    logic                    overflow;
    logic                    done;

    int tests = 0;
    int fails = 0;

    count_display_driver #(.WIDTH(WIDTH), .NUM_DIGITS(NUM_DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .bin_in   (bin_in),
        .bcd_out  (bcd_out),
        .hex_out  (hex_out),
        .overflow (overflow),
        .done     (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference segment table, {g..a} active-low
    logic [6:0] seg_tab [10];
    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model_bcd(input int unsigned v);
        logic [23:0] r;
        r = '0;
        if (v > 999999) return 24'h999999;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [41:0] model_hex(input int unsigned v);
        logic [41:0] r;
        int unsigned p;
        int unsigned d;
        p = 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = (v > 999999) ? 9 : (v / p) % 10;
            r[7*i +: 7] = seg_tab[d];
`ifdef LEADING_ZERO_BLANK_EN
            if (v <= 999999 && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [41:0] reset_hex();
        logic [41:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) r[7*i +: 7] = seg_tab[0];
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < NUM_DIGITS; i++) r[7*i +: 7] = 7'h7F;
`endif
        return r;
    endfunction

    // Returns the number of rising edges until done was seen high (bounded)
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!done && cycles < budget);
        check("done_seen", done, 1'b1);
    endtask

    task automatic check_value(input string tag, input int unsigned v);
        check({tag, "_bcd"}, bcd_out, model_bcd(v));
        check({tag, "_hex"}, hex_out, model_hex(v));
        check({tag, "_ovf"}, overflow, v > 999999);
    endtask

    // Apply a new value from IDLE and check latency, outputs and done pulse width
    task automatic apply(input string tag, input int unsigned v);
        int c;
        bin_in = WIDTH'(v);
        wait_done(2 * LATENCY, c);
        check({tag, "_latency"}, c, LATENCY);
        check_value(tag, v);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] bin;
        logic [23:0]      bcd;
        logic             ovf;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int c;
        int unsigned v;
        int unsigned cur;

        vecs[0] = '{bin: 23'd123456,  bcd: 24'h123456, ovf: 1'b0};
        vecs[1] = '{bin: 23'd8388607, bcd: 24'h999999, ovf: 1'b1};
        vecs[2] = '{bin: 23'd999999,  bcd: 24'h999999, ovf: 1'b0};
        vecs[3] = '{bin: 23'd1000000, bcd: 24'h999999, ovf: 1'b1};
        vecs[4] = '{bin: 23'd305,     bcd: 24'h000305, ovf: 1'b0};
        vecs[5] = '{bin: 23'd0,       bcd: 24'h000000, ovf: 1'b0};
        vecs[6] = '{bin: 23'd7,       bcd: 24'h000007, ovf: 1'b0};
        vecs[7] = '{bin: 23'd100000,  bcd: 24'h100000, ovf: 1'b0};
        vecs[8] = '{bin: 23'd99999,   bcd: 24'h099999, ovf: 1'b0};

        // Reset state
        rst    = 1'b1;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd",  bcd_out,  24'h0);
        check("rst_hex",  hex_out,  reset_hex());
        check("rst_ovf",  overflow, 1'b0);
        check("rst_done", done,     1'b0);

        // Forced conversion of 0 after release
        rst = 1'b0;
        wait_done(2 * LATENCY, c);
        check("init_latency", c, LATENCY);
        check_value("init", 0);
        check("init_hex_all0", hex_out, reset_hex());
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            bin_in = vecs[i].bin;
            wait_done(2 * LATENCY, c);
            check($sformatf("vec%0d_latency", i), c, LATENCY);
            check($sformatf("vec%0d_bcd", i), bcd_out, vecs[i].bcd);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
            check($sformatf("vec%0d_hex", i), hex_out, model_hex(vecs[i].bin));
            if (i == 0) begin
                check("vec0_dig0_seg6", hex_out[6:0],   7'h02);
                check("vec0_dig5_seg1", hex_out[41:35], 7'h79);
            end
`ifdef LEADING_ZERO_BLANK_EN
            if (i == 4)
                check("blank_305", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12});
`endif
            @(posedge clk);
            #1;
        end

        // Input change mid-SHIFT: first result is the old value, then the new one
        bin_in = 23'd42;
        repeat (10) @(posedge clk);
        #1;
        bin_in = 23'd77;
        wait_done(2 * LATENCY, c);
        check("mid_first_cycles", c, LATENCY - 10);
        check_value("mid_first", 42);
        wait_done(50, c);
        check("mid_second_cycles", c, LATENCY);
        check_value("mid_second", 77);
        @(posedge clk);
        #1;

        // Reset mid-conversion: outputs return to reset values without a clock edge
        bin_in = 23'd654321;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_bcd",  bcd_out,  24'h0);
        check("abort_hex",  hex_out,  reset_hex());
        check("abort_ovf",  overflow, 1'b0);
        check("abort_done", done,     1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_done(2 * LATENCY, c);
        check("abort_reconv_latency", c, LATENCY);
        check_value("abort_reconv", 654321);
        @(posedge clk);
        #1;

        // Randomized values against the decimal model
        cur = 654321;
        for (int k = 0; k < 25; k++) begin
            v = $urandom_range(0, 23'h7FFFFF) >> $urandom_range(0, 22);
            if (v == cur) v = v ^ 1;
            cur = v;
            apply($sformatf("rnd%0d", k), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
